comma_aligner: RTL and testbench

- Word aligner directly upstream of the Dec8B10B decoder.
- Takes raw, unaligned 10-bit parallel words from the deserializer and finds the 8B/10B comma pattern (0011111 / 1100000) at any of 10 bit offsets.
- Locks onto that offset, barrel-shifts the stream so every output word is a whole code group, and feeds Dec8B10B.
- Uses the decoder's code_err feedback to detect loss of alignment and re-hunt.

---
 rtl/comma_aligner.sv | 149 ++++++++++++++
 tb/tb_comma_aligner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner.sv
// Word aligner ahead of the 8B/10B decoder: finds the comma (0011111 /
// 1100000) at any of the 10 bit offsets of the raw deserializer stream,
// locks onto that offset and re-hunts when the decoder keeps reporting
// code errors.
module comma_aligner #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] in,
  input  logic       code_err_in,
  output logic [9:0] out,
  output logic       out_valid,
  output logic       comma,
  output logic       locked,
  output logic [3:0] offset
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  // Counters stick at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic is_comma(input logic [6:0] b);
    return (b == 7'b0011111) || (b == 7'b1100000);
  endfunction

  logic [19:0] hist_p0;
  logic [9:0]  cand [10];
  logic [9:0]  comma_vec;
  logic [3:0]  first_k;
  logic        any_comma;
  logic [9:0]  cand_sel;
  logic        comma_sel;

  state_t      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  offset_q, offset_d;

  // Stage 0: two-word history; older word in the upper half, in[9] first in time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist_p0 <= '0;
    else        hist_p0 <= {hist_p0[9:0], in};
  end

  // Extract all ten candidate code groups, flag commas, find the lowest comma offset.
  always_comb begin
    comma_vec = '0;
    first_k   = '0;
    for (int k = 0; k < 10; k++) begin
      cand[k]      = hist_p0[(19 - k) -: 10];
      comma_vec[k] = is_comma(cand[k][9:3]);
    end
    for (int k = 9; k >= 0; k--) begin
      if (comma_vec[k]) first_k = 4'(k);
    end
    any_comma = |comma_vec;
  end

  // Select the candidate at the currently held offset.
  always_comb begin
    cand_sel  = '0;
    comma_sel = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (offset_q == 4'(k)) begin
        cand_sel  = cand[k];
        comma_sel = comma_vec[k];
      end
    end
  end

  // Stage 1: aligned output register; valid tracks the state held before the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      comma     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out       <= cand_sel;
      comma     <= comma_sel;
      out_valid <= (state_q == LOCKED);
    end
  end

  // Alignment state and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      match_q  <= '0;
      err_q    <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      err_q    <= err_d;
      offset_q <= offset_d;
    end
  end

  // Hunt for a comma, confirm it at one offset, then watch decoder errors while locked.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    err_d    = err_q;
    offset_d = offset_q;
    case (state_q)
      HUNT: begin
        if (any_comma) begin
          offset_d = first_k;
          match_d  = 4'd1;
          err_d    = '0;
          state_d  = (LOCK_N <= 4'd1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (comma_sel) begin
          match_d = sat_inc(match_q);
          if (sat_inc(match_q) >= LOCK_N) begin
            state_d = LOCKED;
            err_d   = '0;
          end
        end else if (any_comma) begin
          offset_d = first_k;
          match_d  = 4'd1;
        end
      end
      LOCKED: begin
        err_d = code_err_in ? sat_inc(err_q) : 4'd0;
        if ((code_err_in ? sat_inc(err_q) : 4'd0) >= LOSS_N) begin
          state_d = HUNT;
          match_d = '0;
          err_d   = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: builds bit streams of code groups, predicts the
// aligned output words in a scoreboard and the lock/offset timing from the
// position of each comma in the stream.
module tb_comma_aligner;

  localparam int LOCK = 3;
  localparam int LOSS = 4;
  localparam logic [9:0] K28_5N = 10'b0011111010;
  localparam logic [9:0] K28_5P = 10'b1100000101;
  localparam logic [9:0] D21_5  = 10'b1010101010;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] in = '0;
  logic       code_err_in = 1'b0;
  logic [9:0] out;
  logic       out_valid;
  logic       comma;
  logic       locked;
  logic [3:0] offset;

  int n_cmp = 0;
  int n_bad = 0;

  logic        bitq [$];
  logic [10:0] exp_q [$];
  logic [10:0] mon_e;
  int          nbits, nsamp, ks, first_word, lock_word;
  bit          sb_en;
  logic [3:0]  exp_off;
  int          errs [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0};

  comma_aligner #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS)) dut (
    .clock      (clock),
    .reset      (reset),
    .in         (in),
    .code_err_in(code_err_in),
    .out        (out),
    .out_valid  (out_valid),
    .comma      (comma),
    .locked     (locked),
    .offset     (offset)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard drain: each valid aligned word is the next predicted code group.
  always @(negedge clock) begin
    if (out_valid && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("out", 32'(out), 32'(mon_e[9:0]));
      check("comma", 32'(comma), 32'(mon_e[10]));
    end
  end

  task automatic new_stream(input bit track, input logic [3:0] off);
    bitq.delete();
    exp_q.delete();
    nbits = 0; nsamp = 0; ks = 0;
    first_word = -100; lock_word = -100;
    sb_en = track; exp_off = off;
  endtask

  task automatic realign(input logic [3:0] off);
    ks = 0; exp_off = off;
    first_word = -100; lock_word = -100;
  endtask

  task automatic add_group(input logic [9:0] g, input bit is_k);
    if (sb_en && ks >= LOCK) exp_q.push_back({is_k, g});
    if (is_k) begin
      if (ks == 0) first_word = nbits / 10;
      ks++;
      if (ks == LOCK) lock_word = nbits / 10;
    end
    for (int i = 9; i >= 0; i--) bitq.push_back(g[i]);
    nbits += 10;
  endtask

  task automatic add_zeros(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
    nbits += n;
  endtask

  task automatic add_kd(input int n, input logic [9:0] kc);
    for (int i = 0; i < n; i++) begin
      add_group(kc, 1'b1);
      add_group(D21_5, 1'b0);
    end
  endtask

  // A group starting in word w is judged by the FSM on the edge sampling word w+2.
  task automatic drive_word(input logic err);
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
    in = w;
    code_err_in = err;
    @(posedge clock);
    nsamp++;
    #1;
    if (nsamp == first_word + 3) begin
      check("sync_offset", 32'(offset), 32'(exp_off));
      check("sync_unlocked", 32'(locked), 32'd0);
    end
    if (nsamp == lock_word + 2) check("pre_lock", 32'(locked), 32'd0);
    if (nsamp == lock_word + 3) begin
      check("lock", 32'(locked), 32'd1);
      check("lock_offset", 32'(offset), 32'(exp_off));
    end
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) drive_word(1'b0);
  endtask

  task automatic finish_run();
    run_words((nbits + 9) / 10);
    @(negedge clock);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0; in = '0; code_err_in = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_comma", 32'(comma), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    // Offset-0 lock on RD- commas
    do_reset();
    new_stream(1'b1, 4'd0);
    add_kd(8, K28_5N);
    add_zeros(30);
    finish_run();

    // Stream delayed by 3 bits
    do_reset();
    new_stream(1'b1, 4'd3);
    add_zeros(3);
    add_kd(8, K28_5N);
    add_zeros(30);
    finish_run();

    // Two commas at offset 0, then a 5-bit slip while in SYNC
    do_reset();
    new_stream(1'b1, 4'd0);
    add_kd(2, K28_5N);
    add_zeros(5);
    realign(4'd5);
    add_kd(8, K28_5N);
    add_zeros(30);
    finish_run();

    // Loss of lock after 4 consecutive code errors
    do_reset();
    new_stream(1'b0, 4'd0);
    add_kd(12, K28_5N);
    run_words(lock_word + 3);
    for (int i = 0; i < 10; i++) begin
      drive_word(errs[i][0]);
      if (i < 7) check("err_hold_lock", 32'(locked), 32'd1);
      else       check("err_lost_lock", 32'(locked), 32'd0);
      if (i == 7) check("err_valid_last", 32'(out_valid), 32'd1);
      if (i == 8) check("err_valid_drop", 32'(out_valid), 32'd0);
    end
    code_err_in = 1'b0;

    // RD+ comma
    do_reset();
    new_stream(1'b1, 4'd0);
    add_kd(8, K28_5P);
    add_zeros(30);
    finish_run();

    // Asynchronous reset while locked, then full re-acquisition
    do_reset();
    new_stream(1'b0, 4'd0);
    add_kd(8, K28_5N);
    run_words(lock_word + 4);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_out", 32'(out), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    check("async_offset", 32'(offset), 32'd0);
    #3;
    reset = 1'b1;
    new_stream(1'b1, 4'd0);
    add_kd(8, K28_5N);
    add_zeros(30);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
